bitonic_sort_drain: RTL and testbench
=====================================

# bitonic_sort_drain

Reader-side companion to the bitonic sort network. Accepts fully sorted STREAM_WIDTH-wide vectors at the network output and buffers up to two of them. Emits their elements one per cycle in ascending order over a valid/ready stream. Discards padding sentinels, terminates each vector early at the first pad, and flags ordering violations.

## Interface
- STREAM_WIDTH, `STREAM_WIDTH: elements per sorted vector (power of 2, ≥2)
- LOG_STREAM_WIDTH, `LOG_STREAM_WIDTH: log2(STREAM_WIDTH)
- ROW_IDX_WIDTH, `BITS_ROW_IDX: row-index field width; occupies element MSBs
- DATA_WIDTH, `BITS_ROW_IDX + `DATA_PRECISION: element width {row_idx, value}
- clk  in  1  single clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- vec_valid  in  1  sorted vector present on vec_din
- vec_ready  out  1  buffer can accept a vector this cycle
- vec_din  in  [STREAM_WIDTH][DATA_WIDTH]  sorted vector; index 0 = smallest
- vec_last  in  1  vector closes the current segment
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  DATA_WIDTH  current element
- out_last  out  1  final beat of a segment
- order_err  out  1  sticky ordering-violation flag

## Operation
- Pad element: row_idx field all ones. Pads sort to the top of a vector, so the first pad ends the vector.
- Buffer: two vector slots plus per-slot last bit, kept in FIFO order (wr_ptr, rd_ptr, 2-bit occupancy count).
- Accept on vec_valid & vec_ready; vec_ready = (count < 2).
- The drain reads the head slot through element index elem_idx (LOG_STREAM_WIDTH bits, 0 at slot entry).
  - Element at elem_idx is non-pad: present it; advance elem_idx on out_valid & out_ready.
  - Slot retires on the same handshake when elem_idx = STREAM_WIDTH-1 or element elem_idx+1 is pad. elem_idx then returns to 0 and rd_ptr advances.
  - Element 0 is pad (all-pad vector), last bit = 0: the slot retires in one cycle with no beat; out_valid stays 0.
  - Element 0 is pad, last bit = 1: emit one terminator beat with out_data = all-ones pad and out_last = 1. The slot retires on its handshake.
- out_last = 1 on the retiring beat of a slot whose last bit is set; otherwise 0.
- order_err: set when an emitted non-pad element's row_idx is less than the previous element's row_idx within the same vector. Equal is legal. Cleared only by reset.
- State per slot: EMPTY → FULL on accept; FULL → EMPTY on retire. Accept and retire in the same cycle leave count unchanged.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, order_err 0, count 0, elem_idx 0. vec_ready is 1 immediately after reset releases.
- Latency: vector accepted at cycle t gives first out_valid at t+1 (registered output).
- Throughput: one element per cycle. A vector with k non-pad elements occupies k output cycles. An all-pad non-last vector costs one idle cycle.
- vec_ready depends only on registered occupancy, never combinationally on out_ready.
- When count = 2 and the head slot retires in cycle t, vec_ready rises at t+1.
- out_valid & !out_ready: out_data and out_last are held stable. No element is skipped or duplicated.
- Reset mid-operation: both slots are discarded and all outputs return to reset values asynchronously.

## Test plan
- STREAM_WIDTH=4, vector rows {1,3,5,7}, vec_last=1, out_ready=1 → beats 1,3,5,7 on cycles t+1..t+4; out_last only on 7; order_err 0.
- Vector rows {2,9,pad,pad}, last=0, followed by {4,pad,pad,pad}, last=1 → beats 2,9,4; out_last only on 4; second vector's first beat follows 9 with no gap.
- All-pad vector, last=0, then all-pad vector, last=1 → zero beats for the first; one beat out_data=all-ones with out_last=1 for the second.
- Three back-to-back vectors with out_ready=0 → vec_ready drops after the second accept; the third is held. Release out_ready → all 12 elements in order; vec_ready returns the cycle after the first retire.
- Random out_ready toggling over 100 full vectors → scoreboard shows no loss or duplication; out_data stable during every stall.
- Vector rows {5,3,6,8} → order_err rises with beat 3 and stays 1. Assert rst_b low mid-drain → outputs reset at once; post-reset vectors drain cleanly.

Source files
------------

// File: rtl/bitonic_sort_drain.sv
// Two-slot buffer behind the bitonic sort network: streams each sorted vector
// out one element per cycle, stopping at the first pad and flagging row-order violations.
module bitonic_sort_drain #(
  parameter int STREAM_WIDTH     = 4,
  parameter int LOG_STREAM_WIDTH = $clog2(STREAM_WIDTH),
  parameter int ROW_IDX_WIDTH    = 4,
  parameter int DATA_PRECISION   = 8,
  parameter int DATA_WIDTH       = ROW_IDX_WIDTH + DATA_PRECISION
) (
  input  logic                                   clk,
  input  logic                                   rst_b,
  input  logic                                   vec_valid,
  output logic                                   vec_ready,
  input  logic [STREAM_WIDTH-1:0][DATA_WIDTH-1:0] vec_din,
  input  logic                                   vec_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic                                   out_last,
  output logic                                   order_err
);

  typedef logic [DATA_WIDTH-1:0]                   elem_t;
  typedef logic [STREAM_WIDTH-1:0][DATA_WIDTH-1:0] vec_t;
  typedef logic [LOG_STREAM_WIDTH-1:0]             idx_t;

  localparam idx_t LAST_IDX = idx_t'(STREAM_WIDTH - 1);

  function automatic logic is_pad(input elem_t e);
    return &e[DATA_WIDTH-1 -: ROW_IDX_WIDTH];
  endfunction

  function automatic logic [ROW_IDX_WIDTH-1:0] row_of(input elem_t e);
    return e[DATA_WIDTH-1 -: ROW_IDX_WIDTH];
  endfunction

  // True when the beat at index i is the final beat the slot will produce.
  function automatic logic ends_at(input vec_t v, input idx_t i);
    idx_t nxt;
    nxt = i + idx_t'(1);
    return is_pad(v[i]) || (i == LAST_IDX) || is_pad(v[nxt]);
  endfunction

  vec_t       slot_q [2];
  vec_t       slot_d [2];
  logic [1:0] last_q, last_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  idx_t       elem_idx_q, elem_idx_d;
  logic       vec_ready_q, vec_ready_d;
  logic       out_valid_q, out_valid_d;
  elem_t      out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       order_err_q, order_err_d;

  vec_t  head_s, nhead_s;
  logic  head_last_s, nhead_last_s;
  logic  cur_pad_s, npad_s;
  logic  fire_s, accept_s, retire_s;
  elem_t nelem_s;

  // Next-state of buffer, drain position and the registered output beat
  always_comb begin
    head_s      = slot_q[rd_ptr_q];
    head_last_s = last_q[rd_ptr_q];
    cur_pad_s   = is_pad(head_s[elem_idx_q]);
    fire_s      = out_valid_q & out_ready;
    accept_s    = vec_valid & vec_ready_q;

    if (count_q == 2'd0) begin
      retire_s = 1'b0;
    end else if (cur_pad_s && !head_last_s) begin
      retire_s = 1'b1;
    end else begin
      retire_s = fire_s && ends_at(head_s, elem_idx_q);
    end

    count_d  = count_q + {1'b0, accept_s} - {1'b0, retire_s};
    wr_ptr_d = wr_ptr_q ^ accept_s;
    rd_ptr_d = rd_ptr_q ^ retire_s;

    if (retire_s) begin
      elem_idx_d = idx_t'(0);
    end else if (fire_s) begin
      elem_idx_d = elem_idx_q + idx_t'(1);
    end else begin
      elem_idx_d = elem_idx_q;
    end

    slot_d           = slot_q;
    last_d           = last_q;
    slot_d[wr_ptr_q] = accept_s ? vec_din  : slot_q[wr_ptr_q];
    last_d[wr_ptr_q] = accept_s ? vec_last : last_q[wr_ptr_q];

    // Outputs are computed from the post-edge state so a fresh vector shows a cycle after accept
    nhead_s      = slot_d[rd_ptr_d];
    nhead_last_s = last_d[rd_ptr_d];
    nelem_s      = nhead_s[elem_idx_d];
    npad_s       = is_pad(nelem_s);

    out_valid_d = (count_d != 2'd0) && (!npad_s || nhead_last_s);
    if (!out_valid_d) begin
      out_data_d = '0;
    end else if (npad_s) begin
      out_data_d = '1;
    end else begin
      out_data_d = nelem_s;
    end
    out_last_d  = out_valid_d && nhead_last_s && ends_at(nhead_s, elem_idx_d);
    order_err_d = order_err_q
                | (out_valid_d && !npad_s && (elem_idx_d != idx_t'(0))
                   && (row_of(nelem_s) < row_of(nhead_s[elem_idx_d - idx_t'(1)])));
    vec_ready_d = (count_d < 2'd2);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      slot_q[0]   <= '0;
      slot_q[1]   <= '0;
      last_q      <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      elem_idx_q  <= idx_t'(0);
      vec_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      elem_idx_q  <= elem_idx_d;
      vec_ready_q <= vec_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      order_err_q <= order_err_d;
    end
  end

  assign vec_ready = vec_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign order_err = order_err_q;

endmodule

// File: tb/tb_bitonic_sort_drain.sv
// Self-checking bench for bitonic_sort_drain: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_bitonic_sort_drain;
  localparam int SW = 4;
  localparam int LW = 2;
  localparam int RW = 4;
  localparam int DP = 8;
  localparam int DW = RW + DP;

  typedef logic [DW-1:0]         elem_t;
  typedef logic [SW-1:0][DW-1:0] vec_t;

  logic  clk = 1'b0;
  logic  rst_b = 1'b1;
  logic  vec_valid = 1'b0;
  logic  vec_ready;
  vec_t  vec_din = '0;
  logic  vec_last = 1'b0;
  logic  out_valid;
  logic  out_ready = 1'b0;
  elem_t out_data;
  logic  out_last;
  logic  order_err;

  always #5 clk = ~clk;

  bitonic_sort_drain #(
    .STREAM_WIDTH(SW), .LOG_STREAM_WIDTH(LW), .ROW_IDX_WIDTH(RW),
    .DATA_PRECISION(DP), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_b(rst_b), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_din(vec_din), .vec_last(vec_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .order_err(order_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {elem_t d; logic l; logic e; int c;} beat_t;
  beat_t beats[$];
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Collector: records every handshaken beat and checks that stalled beats hold still
  logic  stall_q = 1'b0;
  elem_t held_d  = '0;
  logic  held_l  = 1'b0;
  always @(negedge clk) begin
    if (!rst_b) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q)
        chk("stall_hold", {18'b0, out_valid, out_last, out_data}, {18'b0, 1'b1, held_l, held_d});
      if (out_valid && out_ready) beats.push_back('{out_data, out_last, order_err, cyc});
      stall_q <= out_valid && !out_ready;
      held_d  <= out_data;
      held_l  <= out_last;
    end
  end

  function automatic elem_t mk(input int row, input int val);
    elem_t e;
    e[DW-1 -: RW] = row[RW-1:0];
    e[DP-1:0]     = val[DP-1:0];
    return e;
  endfunction

  function automatic vec_t mk4(input int r0, input int r1, input int r2, input int r3);
    vec_t v;
    int   r[4];
    r = '{r0, r1, r2, r3};
    for (int i = 0; i < SW; i++) v[i] = (r[i] == 15) ? mk(15, 60) : mk(r[i], 16 * i + r[i]);
    return v;
  endfunction

  function automatic vec_t rand_vec(input int nreal);
    vec_t v;
    int   r;
    r = int'($urandom_range(0, 3));
    for (int i = 0; i < SW; i++) begin
      if (i < nreal) begin
        v[i] = mk(r, int'($urandom_range(0, 255)));
        r = r + int'($urandom_range(0, 3));
        if (r > 14) r = 14;
      end else begin
        v[i] = mk(15, int'($urandom_range(0, 255)));
      end
    end
    return v;
  endfunction

  // Reference: non-pad prefix in order, last on the final one, lone terminator for an empty last vector
  function automatic void model(input vec_t v, input logic last);
    int    n;
    beat_t b;
    n = 0;
    for (int i = 0; i < SW; i++) begin
      if (v[i][DW-1 -: RW] == {RW{1'b1}}) break;
      b.d = v[i]; b.l = 1'b0; b.e = 1'b0; b.c = 0;
      exp_q.push_back(b);
      n++;
    end
    if (n == 0 && last) begin
      b.d = '1; b.l = 1'b1; b.e = 1'b0; b.c = 0;
      exp_q.push_back(b);
    end else if (n > 0 && last) begin
      exp_q[exp_q.size() - 1].l = 1'b1;
    end
  endfunction

  task automatic cmp_stream(input string name);
    chk({name, "_count"}, beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      chk({name, "_data"}, 32'(beats[i].d), 32'(exp_q[i].d));
      chk({name, "_last"}, 32'(beats[i].l), 32'(exp_q[i].l));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input logic last, output int acc);
    logic ok;
    ok  = 1'b0;
    acc = -1;
    vec_din = v; vec_last = last; vec_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (vec_ready) begin ok = 1'b1; acc = cyc; end
      @(posedge clk);
      #1;
    end
    vec_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 2000 && beats.size() < n; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  typedef struct {vec_t din; logic last; int n; vec_t exp; logic exp_last;} tv_t;
  tv_t  tv[6];
  vec_t term_v;
  vec_t pad_v;
  vec_t rv;
  logic rl;
  logic drv_done;
  int   acc, acc2, rise;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pad_v  = mk4(15, 15, 15, 15);
    term_v = '0;
    term_v[0] = '1;
    tv[0] = '{din: mk4(1, 3, 5, 7),     last: 1'b1, n: 4, exp: mk4(1, 3, 5, 7),     exp_last: 1'b1};
    tv[1] = '{din: mk4(2, 9, 15, 15),   last: 1'b0, n: 2, exp: mk4(2, 9, 15, 15),   exp_last: 1'b0};
    tv[2] = '{din: mk4(4, 15, 15, 15),  last: 1'b1, n: 1, exp: mk4(4, 15, 15, 15),  exp_last: 1'b1};
    tv[3] = '{din: pad_v,               last: 1'b0, n: 0, exp: pad_v,               exp_last: 1'b0};
    tv[4] = '{din: pad_v,               last: 1'b1, n: 1, exp: term_v,              exp_last: 1'b1};
    tv[5] = '{din: mk4(0, 0, 14, 14),   last: 1'b0, n: 4, exp: mk4(0, 0, 14, 14),   exp_last: 1'b0};

    #2 rst_b = 1'b0;
    #10;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rst_vec_ready", 32'(vec_ready), 32'd1);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_order_err", 32'(order_err), 32'd0);
    cycles(1);

    // Directed table: each vector alone, ready always high
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      beats.delete();
      send(tv[k].din, tv[k].last, acc);
      cycles(6);
      chk("tbl_count", beats.size(), tv[k].n);
      for (int i = 0; i < tv[k].n && i < beats.size(); i++) begin
        chk("tbl_data", 32'(beats[i].d), 32'(tv[k].exp[i]));
        chk("tbl_last", 32'(beats[i].l), 32'(tv[k].exp_last && (i == tv[k].n - 1)));
        chk("tbl_cycle", beats[i].c, acc + 1 + i);
        chk("tbl_order_err", 32'(beats[i].e), 32'd0);
      end
    end

    // Partial vector followed immediately by a short last vector
    beats.delete(); exp_q.delete();
    send(mk4(2, 9, 15, 15), 1'b0, acc);
    send(mk4(4, 15, 15, 15), 1'b1, acc2);
    model(mk4(2, 9, 15, 15), 1'b0);
    model(mk4(4, 15, 15, 15), 1'b1);
    wait_beats(3);
    cycles(3);
    cmp_stream("pair");
    if (beats.size() >= 3) chk("pair_nogap", beats[2].c, beats[1].c + 1);

    // All-pad non-last then all-pad last
    beats.delete(); exp_q.delete();
    send(pad_v, 1'b0, acc);
    send(pad_v, 1'b1, acc2);
    model(pad_v, 1'b0);
    model(pad_v, 1'b1);
    cycles(6);
    cmp_stream("allpad");

    // Three vectors against a stalled sink
    beats.delete(); exp_q.delete();
    out_ready = 1'b0;
    send(mk4(1, 2, 3, 4), 1'b1, acc);
    send(mk4(5, 6, 7, 8), 1'b1, acc);
    model(mk4(1, 2, 3, 4), 1'b1);
    model(mk4(5, 6, 7, 8), 1'b1);
    model(mk4(9, 10, 11, 12), 1'b1);
    vec_din = mk4(9, 10, 11, 12); vec_last = 1'b1; vec_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_vec_ready", 32'(vec_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    rise = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vec_ready) begin rise = cyc; break; end
    end
    @(posedge clk);
    #1 vec_valid = 1'b0;
    wait_beats(12);
    cycles(2);
    cmp_stream("b2b3");
    if (beats.size() >= 4) chk("b2b3_ready_rise", rise, beats[3].c + 1);
    else chk("b2b3_ready_rise", rise, 32'd0);

    // Randomized traffic with random sink back-pressure
    beats.delete(); exp_q.delete();
    drv_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          rv = rand_vec(($urandom_range(0, 3) != 0) ? SW : int'($urandom_range(0, 3)));
          rl = 1'($urandom_range(0, 1));
          model(rv, rl);
          send(rv, rl, acc);
          if ($urandom_range(0, 3) == 0) cycles(1);
        end
        drv_done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000 && !drv_done; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_beats(exp_q.size());
    cycles(3);
    cmp_stream("rand");
    chk("rand_order_err", 32'(order_err), 32'd0);

    // Ordering violation is flagged with the offending beat and sticks
    beats.delete();
    send(mk4(5, 3, 6, 8), 1'b1, acc);
    cycles(6);
    chk("oerr_count", beats.size(), 32'd4);
    if (beats.size() >= 2) begin
      chk("oerr_before", 32'(beats[0].e), 32'd0);
      chk("oerr_at_3", 32'(beats[1].e), 32'd1);
      chk("oerr_beat3_data", 32'(beats[1].d), 32'(mk(3, 19)));
    end
    chk("oerr_sticky", 32'(order_err), 32'd1);

    // Asynchronous reset in the middle of a drain
    send(mk4(1, 2, 3, 4), 1'b1, acc);
    @(negedge clk);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data",  32'(out_data),  32'd0);
    chk("mid_rst_out_last",  32'(out_last),  32'd0);
    chk("mid_rst_order_err", 32'(order_err), 32'd0);
    chk("mid_rst_vec_ready", 32'(vec_ready), 32'd1);
    cycles(2);
    rst_b = 1'b1;
    cycles(1);
    beats.delete(); exp_q.delete();
    send(mk4(2, 4, 6, 8), 1'b1, acc);
    model(mk4(2, 4, 6, 8), 1'b1);
    wait_beats(4);
    cycles(2);
    cmp_stream("post_rst");
    chk("post_rst_order_err", 32'(order_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
